alu_multicycle: RTL and testbench
=================================

# alu_multicycle

Parametrised, multi-cycle successor to the fixed 3-bit lab ALU. It takes WIDTH-bit unsigned operands and a 3-bit opcode through a start/busy/done handshake. Logic and add/sub ops complete in one cycle; MUL (shift-add) and DIV (restoring) iterate one bit per cycle. It sits between the operand registers and the result display path and registers a 2·WIDTH-bit result.

## Interface
- WIDTH, 8: operand width in bits, ≥2.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while busy=0.
- opcode  in  3  operation select; sampled with start.
- portA  in  WIDTH  operand A (unsigned); sampled with start.
- portB  in  WIDTH  operand B (unsigned); sampled with start.
- out  out  2·WIDTH  registered result; holds until the next completion.
- busy  out  1  high from the cycle after accept until done drops.
- done  out  1  one-cycle pulse; out is valid in this cycle.
- err  out  1  registered with out; high on divide-by-zero or unsupported opcode.

## Operation
- Opcodes:
  - 0 ADD: out = zero-extended A+B (carry lands in bit WIDTH).
  - 1 SUB: out = (A−B) mod 2^(2·WIDTH).
  - 2 MUL: out = A·B.
  - 3 DIV: out = {remainder, quotient}, each WIDTH bits.
  - 4 AND, 5 OR, 6 XOR: out = zero-extended bitwise result.
  - 7 reserved: out = 0, err = 1.
- FSM states IDLE, MUL, DIV, DONE:
  - IDLE & start & opcode=2 → MUL; operands latched; iteration counter = WIDTH−1.
  - IDLE & start & opcode=3 → DIV; same latching and counter.
  - IDLE & start & any other opcode → DONE; result computed and registered on the accept edge.
  - MUL/DIV: one partial-product or partial-remainder step per cycle. At counter=0 → DONE.
  - DONE → IDLE unconditionally; done=1 for this cycle only.
- start while busy=1 (MUL, DIV, DONE) is ignored, not queued.
- DIV with B=0: no iteration; goes straight to DONE with quotient = all ones, remainder = A, err=1.
- err clears to 0 on every completion that is not an error case.
- Reset values: out=0, busy=0, done=0, err=0, state=IDLE, counter=0.
- Reset mid-operation aborts the operation. No done pulse is issued and out is zeroed.

## Timing
- Accept edge is the rising edge where IDLE & start.
- Single-cycle ops: done=1 in the cycle after the accept edge (latency 1).
- MUL and nonzero DIV: done=1 exactly WIDTH+1 cycles after the accept edge.
- DIV by zero: latency 1.
- busy=1 in every cycle from the cycle after the accept edge through the done cycle inclusive.
- Back-to-back throughput:
  - A new start is accepted on the edge ending the done cycle? No. The FSM is in DONE then, so that start is ignored.
  - A new start is accepted no earlier than the edge after done deasserts.
  - Minimum issue interval is 2 cycles for single-cycle ops and WIDTH+2 cycles for iterative ops.
- rst has priority over start on the same edge.

## Configuration
- ALU_DIV_EN:
  - Defined: the restoring divider and the DIV state are compiled in, behaving as above.
  - Undefined: divider logic and the DIV state are omitted. Opcode 3 behaves like opcode 7 (latency 1, out=0, err=1).
  - ADD, SUB, logic and MUL behaviour and timing are identical in both builds.

## Structure
- Shared package alu_pkg:
  - opcode enum/localparams (OP_ADD…OP_RSVD).
  - FSM state encoding.
  - WIDTH-independent constants.
- Natural sub-module alu_iter_unit:
  - Holds the accumulator/remainder registers.
  - Implements one shift-add (MUL) or shift-subtract (DIV) step per enable.
  - Controlled by the top-level FSM and counter.
- Top level: handshake, FSM, single-cycle ops, result/err registers.

## Test plan
- WIDTH=3, rst high 5 cycles, then low → out=0, busy=0, done=0, err=0 throughout reset.
- WIDTH=3, start ADD A=6 B=6 → done 1 cycle later, out=12, err=0.
- WIDTH=3, start SUB A=2 B=6 → out=60 (−4 mod 64), done at latency 1.
- WIDTH=3, start MUL A=6 B=6 → done exactly 4 cycles after accept, out=36. A start pulsed mid-operation is ignored.
- WIDTH=3 with ALU_DIV_EN:
  - DIV A=6 B=4 → out=17 (rem 2, quot 1) at latency 4.
  - DIV A=5 B=0 → out=47, err=1 at latency 1.
  - Without the macro: DIV A=6 B=4 → out=0, err=1 at latency 1.
- WIDTH=8, MUL A=255 B=255 with rst asserted 3 cycles after accept → no done pulse, out=0, busy=0. A fresh MUL 255×255 afterwards → out=65025 at latency 9.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the multi-cycle ALU.
// Used by alu_multicycle and alu_iter_unit; the ALU_DIV_EN build option lives in those files.
package alu_pkg;

    localparam int unsigned OP_W = 3;
    localparam int unsigned ST_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MUL  = 3'd2,
        OP_DIV  = 3'd3,
        OP_AND  = 3'd4,
        OP_OR   = 3'd5,
        OP_XOR  = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath: one shift-add multiply or restoring-divide step per enable.
// The divide step and its mode flag exist only when ALU_DIV_EN is defined.
module alu_iter_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               step_i,
`ifdef ALU_DIV_EN
    input  logic               div_i,
`endif
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] acc_nxt_c_o
);
    import alu_pkg::*;

    localparam int unsigned RES_W = 2 * WIDTH;

    logic [RES_W-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH:0]   mul_sum_c;
    logic [RES_W-1:0] mul_nxt_c;

    // acc holds {upper partial product, unconsumed multiplier bits}; shifts right each step
    always_comb begin
        mul_sum_c = {1'b0, acc_q[RES_W-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : '0)};
        mul_nxt_c = {mul_sum_c, acc_q[WIDTH-1:1]};
    end

`ifdef ALU_DIV_EN
    logic             div_q, div_d;
    logic [WIDTH:0]   div_shift_c;
    logic [WIDTH:0]   div_diff_c;
    logic             div_ge_c;
    logic [WIDTH-1:0] div_rem_c;

    // acc holds {partial remainder, dividend bits shifting into quotient}
    always_comb begin
        div_shift_c = {acc_q[RES_W-1:WIDTH], acc_q[WIDTH-1]};
        div_diff_c  = div_shift_c - {1'b0, b_q};
        div_ge_c    = (div_shift_c >= {1'b0, b_q});
        div_rem_c   = div_ge_c ? div_diff_c[WIDTH-1:0] : div_shift_c[WIDTH-1:0];
        acc_nxt_c_o = div_q ? {div_rem_c, acc_q[WIDTH-2:0], div_ge_c} : mul_nxt_c;
        div_d       = load_i ? div_i : div_q;
    end
`else
    always_comb begin
        acc_nxt_c_o = mul_nxt_c;
    end
`endif

    always_comb begin
        acc_d = acc_q;
        b_d   = b_q;
        if (load_i) begin
            acc_d = {WIDTH'(0), a_i};
            b_d   = b_i;
        end else if (step_i) begin
            acc_d = acc_nxt_c_o;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            b_q   <= '0;
`ifdef ALU_DIV_EN
            div_q <= 1'b0;
`endif
        end else begin
            acc_q <= acc_d;
            b_q   <= b_d;
`ifdef ALU_DIV_EN
            div_q <= div_d;
`endif
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU top: start/busy/done handshake, FSM, single-cycle ops, result registers.
// Define ALU_DIV_EN to build the restoring divider; otherwise opcode 3 reports err like opcode 7.
module alu_multicycle #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         opcode,
    input  logic [WIDTH-1:0]   portA,
    input  logic [WIDTH-1:0]   portB,
    output logic [2*WIDTH-1:0] out,
    output logic               busy,
    output logic               done,
    output logic               err
);
    import alu_pkg::*;

    localparam int unsigned RES_W    = 2 * WIDTH;
    localparam int unsigned CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RES_W-1:0] out_q, out_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [RES_W-1:0] alu_c;
    logic             alu_err_c;
    logic             load_c;
    logic             step_c;
    logic [RES_W-1:0] iter_nxt_c;
`ifdef ALU_DIV_EN
    logic             div_sel_c;
`endif

    alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load_c),
        .step_i      (step_c),
`ifdef ALU_DIV_EN
        .div_i       (div_sel_c),
`endif
        .a_i         (portA),
        .b_i         (portB),
        .acc_nxt_c_o (iter_nxt_c)
    );

    // Single-cycle results; anything not handled here completes with err set
    always_comb begin
        alu_c     = '0;
        alu_err_c = 1'b0;
        case (op_e'(opcode))
            OP_ADD:  alu_c = RES_W'(portA) + RES_W'(portB);
            OP_SUB:  alu_c = RES_W'(portA) - RES_W'(portB);
            OP_AND:  alu_c = RES_W'(portA & portB);
            OP_OR:   alu_c = RES_W'(portA | portB);
            OP_XOR:  alu_c = RES_W'(portA ^ portB);
            default: alu_err_c = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        err_d   = err_q;
        load_c  = 1'b0;
        step_c  = 1'b0;
`ifdef ALU_DIV_EN
        div_sel_c = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op_e'(opcode))
                        OP_MUL: begin
                            state_d = ST_MUL;
                            cnt_d   = CNT_LAST;
                            load_c  = 1'b1;
                        end
`ifdef ALU_DIV_EN
                        OP_DIV: begin
                            if (portB == '0) begin
                                state_d = ST_DONE;
                                out_d   = {portA, {WIDTH{1'b1}}};
                                err_d   = 1'b1;
                            end else begin
                                state_d   = ST_DIV;
                                cnt_d     = CNT_LAST;
                                load_c    = 1'b1;
                                div_sel_c = 1'b1;
                            end
                        end
`endif
                        default: begin
                            state_d = ST_DONE;
                            out_d   = alu_c;
                            err_d   = alu_err_c;
                        end
                    endcase
                end
            end
            // The last step's result is captured on the same edge that enters DONE
            ST_MUL, ST_DIV: begin
                step_c = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    out_d   = iter_nxt_c;
                    err_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle at WIDTH=3 and WIDTH=8 (honours ALU_DIV_EN).
module tb_alu_multicycle;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start3, start8;
    logic [2:0]  op3, op8;
    logic [2:0]  a3, b3;
    logic [7:0]  a8, b8;
    logic [5:0]  out3;
    logic [15:0] out8;
    logic        busy3, done3, err3, busy8, done8, err8;

    alu_multicycle #(.WIDTH(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .opcode(op3), .portA(a3), .portB(b3),
        .out(out3), .busy(busy3), .done(done3), .err(err3)
    );

    alu_multicycle #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .opcode(op8), .portA(a8), .portB(b8),
        .out(out8), .busy(busy8), .done(done8), .err(err8)
    );

    typedef struct {
        bit          sel;
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp_out;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [15:0] out;
        bit          err;
        int          lat;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb_q[$];
    logic [15:0] last_out[2];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] get_out(input bit sel);
        return sel ? out8 : 16'(out3);
    endfunction
    function automatic logic get_busy(input bit sel);
        return sel ? busy8 : busy3;
    endfunction
    function automatic logic get_done(input bit sel);
        return sel ? done8 : done3;
    endfunction
    function automatic logic get_err(input bit sel);
        return sel ? err8 : err3;
    endfunction

    task automatic drive(input bit sel, input bit s, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b);
        if (sel) begin
            start8 = s; op8 = op; a8 = a; b8 = b;
        end else begin
            start3 = s; op3 = op; a3 = a[2:0]; b3 = b[2:0];
        end
    endtask

    task automatic add_vec(input bit sel, input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [15:0] eo, input bit ee, input int el);
        vec_t v;
        v.sel = sel; v.op = op; v.a = a; v.b = b;
        v.exp_out = eo; v.exp_err = ee; v.exp_lat = el;
        vecs.push_back(v);
    endtask

    // Issue one op from IDLE, optionally poking start mid-op or in the done cycle
    task automatic run_op(input string name, input vec_t v, input int poke_at, input bit poke_done);
        exp_t e;
        exp_t got;
        int   lat;
        bit   seen;
        bit   busy_ok;
        @(negedge clk);
        check({name, " idle"}, 32'({get_busy(v.sel), get_done(v.sel)}), 32'(0));
        check({name, " hold"}, 32'(get_out(v.sel)), 32'(last_out[v.sel]));
        e.out = v.exp_out; e.err = v.exp_err; e.lat = v.exp_lat;
        sb_q.push_back(e);
        drive(v.sel, 1'b1, v.op, v.a, v.b);
        lat = 0; seen = 1'b0; busy_ok = 1'b1;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == poke_at) drive(v.sel, 1'b1, OP_ADD, 8'd1, 8'd1);
            else drive(v.sel, 1'b0, v.op, v.a, v.b);
            if (!get_busy(v.sel)) busy_ok = 1'b0;
            if (get_done(v.sel)) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: no done after %0d cycles", name, lat);
            void'(sb_q.pop_front());
        end else begin
            got = sb_q.pop_front();
            check({name, " out"}, 32'(get_out(v.sel)), 32'(got.out));
            check({name, " err"}, 32'(get_err(v.sel)), 32'(got.err));
            check({name, " latency"}, 32'(lat), 32'(got.lat));
            check({name, " busy"}, 32'(busy_ok), 32'(1));
            last_out[v.sel] = got.out;
            if (poke_done) begin
                drive(v.sel, 1'b1, OP_ADD, 8'd1, 8'd1);
                @(negedge clk);
                drive(v.sel, 1'b0, OP_ADD, 8'd1, 8'd1);
                check({name, " done-cycle start ignored"},
                      32'({get_busy(v.sel), get_done(v.sel)}), 32'(0));
            end
        end
    endtask

    initial begin
        vec_t v;
        bit   spurious;

        rst = 1'b1;
        drive(1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
        drive(1'b1, 1'b0, 3'd0, 8'd0, 8'd0);
        last_out[0] = '0;
        last_out[1] = '0;

        add_vec(0, OP_ADD,  8'd6, 8'd6, 16'd12, 0, 1);
        add_vec(0, OP_SUB,  8'd2, 8'd6, 16'd60, 0, 1);
        add_vec(0, OP_RSVD, 8'd3, 8'd3, 16'd0,  1, 1);
        add_vec(0, OP_AND,  8'd6, 8'd3, 16'd2,  0, 1);
        add_vec(0, OP_OR,   8'd4, 8'd1, 16'd5,  0, 1);
        add_vec(0, OP_XOR,  8'd7, 8'd2, 16'd5,  0, 1);
        add_vec(0, OP_ADD,  8'd7, 8'd7, 16'd14, 0, 1);
        add_vec(0, OP_SUB,  8'd0, 8'd1, 16'd63, 0, 1);
        add_vec(0, OP_MUL,  8'd7, 8'd7, 16'd49, 0, 4);
`ifdef ALU_DIV_EN
        add_vec(0, OP_DIV,  8'd6, 8'd4, 16'd17, 0, 4);
        add_vec(0, OP_DIV,  8'd5, 8'd0, 16'd47, 1, 1);
        add_vec(0, OP_DIV,  8'd7, 8'd2, 16'd11, 0, 4);
`else
        add_vec(0, OP_DIV,  8'd6, 8'd4, 16'd0,  1, 1);
        add_vec(0, OP_DIV,  8'd5, 8'd0, 16'd0,  1, 1);
`endif
        add_vec(0, OP_ADD,  8'd1, 8'd1, 16'd2,  0, 1);
        add_vec(1, OP_ADD,  8'd255, 8'd1,   16'd256,   0, 1);
        add_vec(1, OP_SUB,  8'd0,   8'd1,   16'd65535, 0, 1);
        add_vec(1, OP_XOR,  8'hAA,  8'hFF,  16'h0055,  0, 1);
        add_vec(1, OP_MUL,  8'd200, 8'd3,   16'd600,   0, 9);
`ifdef ALU_DIV_EN
        add_vec(1, OP_DIV,  8'd200, 8'd7,   16'd1052,  0, 9);
        add_vec(1, OP_DIV,  8'd255, 8'd255, 16'd1,     0, 9);
`else
        add_vec(1, OP_DIV,  8'd200, 8'd7,   16'd0,     1, 1);
`endif

        // Outputs held at zero throughout reset
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("reset w3", 32'({out3, busy3, done3, err3}), 32'(0));
            check("reset w8", 32'({out8, busy8, done8, err8}), 32'(0));
        end
        rst = 1'b0;

        foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i], 0, 1'b0);

        // Start pulsed mid-multiply is ignored
        add_vec(0, OP_MUL, 8'd6, 8'd6, 16'd36, 0, 4);
        run_op("mul poke", vecs[$], 2, 1'b0);
        spurious = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done3 || busy3) spurious = 1'b1;
        end
        check("no queued op", 32'(spurious), 32'(0));

        // Start during the done cycle is ignored; next op issues right after
        add_vec(0, OP_ADD, 8'd6, 8'd6, 16'd12, 0, 1);
        run_op("add done poke", vecs[$], 0, 1'b1);
        add_vec(0, OP_SUB, 8'd2, 8'd6, 16'd60, 0, 1);
        run_op("b2b sub", vecs[$], 0, 1'b0);

        // Reset three cycles into a WIDTH=8 multiply aborts it
        @(negedge clk);
        drive(1'b1, 1'b1, OP_MUL, 8'd255, 8'd255);
        @(negedge clk);
        drive(1'b1, 1'b0, OP_MUL, 8'd255, 8'd255);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort out", 32'(out8), 32'(0));
        check("abort busy/done", 32'({busy8, done8}), 32'(0));
        spurious = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8 || busy8) spurious = 1'b1;
        end
        check("abort no done", 32'(spurious), 32'(0));
        last_out[0] = '0;
        last_out[1] = '0;

        add_vec(1, OP_MUL, 8'd255, 8'd255, 16'd65025, 0, 9);
        run_op("mul fresh", vecs[$], 0, 1'b0);

        v = vecs[0];
        run_op("final add", v, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
